// File: rtl/eth_pkg.sv
// Shared Ethernet FCS constants and receive-checker state encoding.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam int          FCS_DIBITS      = 16;

    typedef enum logic [1:0] {
        WAIT,
        IDLE,
        FRAME
    } fcs_state_e;

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 update for one RMII dibit (bit 0 first on the wire).
module crc32_dibit
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    logic [31:0] crc_mid;

    always_comb begin
        crc_mid = (crc_in >> 1) ^ ((crc_in[0] ^ dibit[0]) ? CRC32_POLY_REFL : 32'h0);
        crc_out = (crc_mid >> 1) ^ ((crc_mid[0] ^ dibit[1]) ? CRC32_POLY_REFL : 32'h0);
    end

endmodule

// File: rtl/eth_fcs_check.sv
// Ethernet FCS checker on the post-SFD RMII dibit stream: strips the FCS, flags CRC/runt/oversize.
// Define FCS_ERRCNT_EN to add the saturating err_count output.
module eth_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_DIBITS = 256,
    parameter int MAX_FRAME_DIBITS = 6072,
    parameter int ERRCNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                axiiv,
    input  logic [1:0]          axiid,
    output logic                axiov,
    output logic [1:0]          axiod,
    output logic                done,
`ifdef FCS_ERRCNT_EN
    output logic [ERRCNT_W-1:0] err_count,
`endif
    output logic                kill
);

    localparam int LEN_W = 13;
    localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_FRAME_DIBITS + 1);
    localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(MIN_FRAME_DIBITS);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_FRAME_DIBITS);
    localparam logic [LEN_W-1:0] FWD_START = LEN_W'(FCS_DIBITS);

    // Length counter stops one past the legal maximum so oversize stays detectable.
    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_SAT) ? v : v + 1'b1;
    endfunction

    fcs_state_e       state, state_nxt;
    logic             absorb, close, fwd;
    logic [31:0]      crc, crc_base, crc_nxt;
    logic [LEN_W-1:0] len;
    logic [1:0]       dly [FCS_DIBITS];

    always_comb begin
        state_nxt = state;
        absorb    = 1'b0;
        close     = 1'b0;
        unique case (state)
            WAIT:    if (!axiiv) state_nxt = IDLE;
            IDLE:    if (axiiv) begin
                         absorb    = 1'b1;
                         state_nxt = FRAME;
                     end
            FRAME:   if (axiiv) absorb = 1'b1;
                     else begin
                         close     = 1'b1;
                         state_nxt = IDLE;
                     end
            default: state_nxt = WAIT;
        endcase
    end

    // A first dibit always starts from the seed, even if crc has not been reloaded yet.
    assign crc_base = (state == FRAME) ? crc : CRC32_INIT;
    assign fwd      = (state == FRAME) && (len >= FWD_START);

    crc32_dibit u_crc (
        .crc_in  (crc_base),
        .dibit   (axiid),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT;
            crc   <= CRC32_INIT;
            len   <= '0;
            axiov <= 1'b0;
            axiod <= 2'b00;
            done  <= 1'b0;
            kill  <= 1'b0;
            for (int i = 0; i < FCS_DIBITS; i++) dly[i] <= 2'b00;
        end else begin
            state <= state_nxt;
            axiov <= absorb && fwd;
            axiod <= (absorb && fwd) ? dly[FCS_DIBITS-1] : 2'b00;
            done  <= close;
            kill  <= close && ((crc != CRC32_RESIDUE) || (len < LEN_MIN) || (len > LEN_MAX));
            if (absorb) begin
                crc    <= crc_nxt;
                len    <= (state == FRAME) ? len_inc(len) : LEN_W'(1);
                dly[0] <= axiid;
                for (int i = 1; i < FCS_DIBITS; i++) dly[i] <= dly[i-1];
            end else if (close) begin
                crc <= CRC32_INIT;
                len <= '0;
            end
        end
    end

`ifdef FCS_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (done && kill && (err_count != {ERRCNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_fcs_check.sv
// Bench for eth_fcs_check: directed frame table, hand-written corner sequences, random frames vs a byte-level CRC model.
module tb_eth_fcs_check;

    localparam int MIN_D = 256;
    localparam int MAX_D = 6072;

    logic        clk = 1'b0;
    logic        rst, axiiv;
    logic [1:0]  axiid;
    logic        axiov, done, kill;
    logic [1:0]  axiod;
`ifdef FCS_ERRCNT_EN
    logic [15:0] err_count;
`endif

    always #10 clk = ~clk;

    eth_fcs_check #(
        .MIN_FRAME_DIBITS (MIN_D),
        .MAX_FRAME_DIBITS (MAX_D),
        .ERRCNT_W         (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axiiv     (axiiv),
        .axiid     (axiid),
        .axiov     (axiov),
        .axiod     (axiod),
        .done      (done),
`ifdef FCS_ERRCNT_EN
        .err_count (err_count),
`endif
        .kill      (kill)
    );

    typedef struct {
        int ndib;
        bit flip;
        bit exp_kill;
        int exp_fwd;
    } vec_t;

    typedef struct {
        bit kill;
        int nfwd;
    } rec_t;

    rec_t       rec_q[$];
    logic [1:0] exp_d[$];
    logic [1:0] frm[$];
    int n_vec = 0, n_bad = 0;
    int fwd_seen = 0, data_err = 0;
    int stray_out = 0, stray_done = 0, stray_kill = 0;
    int exp_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Standard Ethernet CRC-32 over bytes, LSB-first, final inversion gives the FCS value.
    function automatic logic [31:0] crc32_ref(input byte unsigned b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void build(input int ndib, input bit flip, input bit rnd);
        byte unsigned pl[$];
        byte unsigned b;
        logic [31:0]  fcs;
        frm.delete();
        if (ndib % 4 == 0 && ndib >= 16) begin
            for (int i = 0; i < ndib / 4 - 4; i++) pl.push_back(rnd ? 8'($urandom) : 8'h00);
            fcs = crc32_ref(pl);
            for (int k = 0; k < 4; k++) pl.push_back(fcs[8*k +: 8]);
            if (flip) pl[5] = pl[5] ^ 8'h08;
            foreach (pl[i]) begin
                b = pl[i];
                for (int j = 0; j < 4; j++) frm.push_back(b[2*j +: 2]);
            end
        end else begin
            for (int i = 0; i < ndib; i++) frm.push_back(2'($urandom));
        end
    endfunction

    // Reassemble bytes and compare the received FCS field against a fresh CRC of the payload.
    function automatic bit model_kill();
        int n = frm.size();
        byte unsigned by[$];
        logic [31:0]  fcs;
        if (n < MIN_D || n > MAX_D || n % 4 != 0) return 1'b1;
        for (int i = 0; i < n / 4; i++) by.push_back({frm[4*i+3], frm[4*i+2], frm[4*i+1], frm[4*i]});
        fcs = {by[n/4-1], by[n/4-2], by[n/4-3], by[n/4-4]};
        for (int k = 0; k < 4; k++) void'(by.pop_back());
        return crc32_ref(by) != fcs;
    endfunction

    task automatic send(input bit exp_kill, input int exp_fwd);
        rec_t r;
        for (int i = 0; i < exp_fwd; i++) exp_d.push_back(frm[i]);
        r.kill = exp_kill;
        r.nfwd = exp_fwd;
        rec_q.push_back(r);
        foreach (frm[i]) begin
            @(posedge clk); #1;
            axiiv = 1'b1;
            axiid = frm[i];
        end
        @(posedge clk); #1;
        axiiv = 1'b0;
        axiid = 2'b00;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (rec_q.size() != 0 || exp_d.size() != 0); i++) @(negedge clk);
        check(name, rec_q.size() + exp_d.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_err = 0;
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (axiov) begin
            if (exp_d.size() == 0) stray_out++;
            else if (axiod !== exp_d.pop_front()) data_err++;
            fwd_seen++;
        end
        if (kill && !done) stray_kill++;
        if (done) begin
            if (rec_q.size() == 0) begin
                stray_done++;
            end else begin
                r = rec_q.pop_front();
                check("kill", kill, r.kill);
                check("fwd_count", fwd_seen, r.nfwd);
                check("fwd_data_errors", data_err, 0);
                check("axiov_at_done", axiov, 0);
                if (r.kill && exp_err < 65535) exp_err++;
            end
            fwd_seen = 0;
            data_err = 0;
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        bit   k;
        tbl[0] = '{256,  1'b0, 1'b0, 240};   // 60 zero bytes + good FCS
        tbl[1] = '{256,  1'b1, 1'b1, 240};   // payload bit flipped
        tbl[2] = '{252,  1'b0, 1'b1, 236};   // 63-byte runt
        tbl[3] = '{10,   1'b0, 1'b1, 0};     // shorter than the FCS
        tbl[4] = '{256,  1'b0, 1'b0, 240};   // one idle cycle after the tiny frame
        tbl[5] = '{6072, 1'b0, 1'b0, 6056};  // maximum legal size
        tbl[6] = '{6076, 1'b0, 1'b1, 6060};  // one byte oversize
        tbl[7] = '{16,   1'b0, 1'b1, 0};     // FCS only
        tbl[8] = '{20,   1'b0, 1'b1, 4};     // one payload byte

        reset_dut();
        check("reset_axiov", axiov, 0);
        check("reset_axiod", axiod, 0);
        check("reset_done", done, 0);
        check("reset_kill", kill, 0);
`ifdef FCS_ERRCNT_EN
        check("reset_err_count", err_count, 0);
`endif

        for (int v = 0; v < 9; v++) begin
            build(tbl[v].ndib, tbl[v].flip, 1'b0);
            send(tbl[v].exp_kill, tbl[v].exp_fwd);
        end
        drain("table_drain");
`ifdef FCS_ERRCNT_EN
        check("err_count_table", err_count, exp_err);

        reset_dut();
        for (int f = 0; f < 4; f++) begin
            build(256, f < 3, 1'b1);
            send(f < 3, 240);
        end
        drain("errcnt_drain");
        check("err_count_3bad", err_count, 3);
        reset_dut();
        check("err_count_after_rst", err_count, 0);
`endif

        // Reset lands on dibit 100; dibits 16..99 were already forwarded as 0..83.
        build(256, 1'b0, 1'b1);
        for (int i = 0; i < 84; i++) exp_d.push_back(frm[i]);
        foreach (frm[i]) begin
            @(posedge clk); #1;
            if (i == 101) begin
                check("midrst_axiov_cleared", axiov, 0);
                check("midrst_done_low", done, 0);
            end
            axiiv = 1'b1;
            axiid = frm[i];
            rst   = (i == 100);
        end
        check("midrst_fwd_count", fwd_seen, 84);
        check("midrst_fwd_data", data_err, 0);
        fwd_seen = 0;
        data_err = 0;
        exp_err  = 0;
        @(posedge clk); #1;
        axiiv = 1'b0;
        build(256, 1'b0, 1'b1);
        send(1'b0, 240);
        drain("midrst_drain");
`ifdef FCS_ERRCNT_EN
        check("err_count_midrst", err_count, 0);
`endif

        for (int f = 0; f < 20; f++) begin
            build(4 * $urandom_range(50, 140), $urandom_range(0, 3) == 0, 1'b1);
            k = model_kill();
            send(k, frm.size() - 16);
        end
        drain("random_drain");
`ifdef FCS_ERRCNT_EN
        check("err_count_random", err_count, exp_err);
`endif

        check("stray_axiov", stray_out, 0);
        check("stray_done", stray_done, 0);
        check("kill_without_done", stray_kill, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
